// File: rtl/hamming_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_pkg                                                                |
// | Shared constants and elaboration-time helpers for the Hamming SECDED       |
// | APB peripheral: register offsets, STATUS bit indices, the pipeline         |
// | payload type and the codeword layout functions.                            |
// | Ports: none (package).                                                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package hamming_pkg;

  // Byte offsets of the register map
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_DIN_LO  = 8'h04;
  localparam logic [7:0] OFF_DIN_HI  = 8'h08;
  localparam logic [7:0] OFF_DOUT_LO = 8'h0C;
  localparam logic [7:0] OFF_DOUT_HI = 8'h10;
  localparam logic [7:0] OFF_STATUS  = 8'h14;
  localparam logic [7:0] OFF_ERR_CNT = 8'h18;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_SEC     = 2;
  localparam int ST_DED     = 3;
  localparam int ST_SYN_LSB = 8;

  // Syndrome width: CODE_W never exceeds 64, so 7 bits always hold s
  localparam int SYN_W = 7;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Payload carried down the datapath pipeline
  typedef struct packed {
    logic             valid;
    logic [63:0]      result;
    logic             sec;
    logic             ded;
    logic [SYN_W-1:0] syndrome;
  } core_out_t;

  // Smallest r with 2^r >= data_w + r + 1
  function automatic int calc_r(input int data_w);
    int r;
    r = 7;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position holding data bit idx (data fills non-power-of-two
  // positions from 3 upward in ascending order)
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bit index stored at a non-power-of-two codeword position
  function automatic int data_idx(input int pos);
    int cnt;
    cnt = 0;
    for (int q = 3; q < 128; q++) begin
      if (q < pos && !is_pow2(q)) cnt++;
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_secded_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_secded_core                                                        |
// | Pipelined SECDED encode/decode datapath. The operand is captured on the    |
// | cycle valid is high; the result appears on valid_out PIPE_STAGES-1 cycles  |
// | later, so a registered consumer sees it PIPE_STAGES cycles after launch.   |
// | Ports:                                                                     |
// |   clk, rst_n        clock, asynchronous active-low reset                   |
// |   mode              0 = encode, 1 = decode                                 |
// |   operand [63:0]    data (encode) or codeword (decode), truncated inside   |
// |   valid             launch strobe                                          |
// |   result [63:0]     codeword or extracted data, zero-extended              |
// |   sec, ded          corrected / uncorrectable flags (decode only)          |
// |   syndrome [6:0]    decode syndrome                                        |
// |   valid_out         result strobe                                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hamming_secded_core
  import hamming_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [63:0]      operand,
  input  logic             valid,
  output logic [63:0]      result,
  output logic             sec,
  output logic             ded,
  output logic [SYN_W-1:0] syndrome,
  output logic             valid_out
);

  localparam int R      = calc_r(DATA_W);
  localparam int CODE_W = DATA_W + R + 1;

  localparam logic [63:0] DATA_MASK = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - DATA_W);
  localparam logic [63:0] CODE_MASK = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - CODE_W);

  // XOR of the indices of all set bits in positions 1..63
  function automatic logic [SYN_W-1:0] syn_of(input logic [63:0] w);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int p = 1; p < 64; p++) begin
      if (w[p]) s = s ^ SYN_W'(p);
    end
    return s;
  endfunction

  // Stage 1: operand capture, truncated to the width the mode consumes
  logic        in_valid;
  logic        in_mode;
  logic [63:0] in_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      in_mode  <= 1'b0;
      in_op    <= '0;
    end else begin
      in_valid <= valid;
      if (valid) begin
        in_mode <= mode;
        in_op   <= mode ? (operand & CODE_MASK) : (operand & DATA_MASK);
      end
    end
  end

  // Data bits scattered into codeword positions, parity positions left zero
  logic [63:0] placed;
  // Data bits gathered back out of the (corrected) received word
  logic [63:0] rx_data;
  logic [63:0] corrected;

  for (genvar p = 0; p < 64; p++) begin : g_place
    if (p == 0 || p >= CODE_W || is_pow2(p)) begin : g_zero
      assign placed[p] = 1'b0;
    end else begin : g_data
      assign placed[p] = in_op[data_idx(p)];
    end
  end

  for (genvar i = 0; i < 64; i++) begin : g_extract
    if (i < DATA_W) begin : g_bit
      assign rx_data[i] = corrected[data_pos(i)];
    end else begin : g_pad
      assign rx_data[i] = 1'b0;
    end
  end

  logic [SYN_W-1:0] enc_syn;
  logic [63:0]      codeword;
  logic [SYN_W-1:0] dec_syn;
  logic             dec_par;
  logic             dec_sec;
  logic             dec_ded;

  always_comb begin
    // Parity bit k equals bit k of the syndrome of the data-only word,
    // which zeroes the syndrome of the finished codeword.
    enc_syn  = syn_of(placed);
    codeword = placed;
    for (int k = 0; k < R; k++) begin
      codeword[1 << k] = enc_syn[k];
    end
    codeword[0] = ^codeword[63:1];

    dec_syn   = syn_of(in_op);
    dec_par   = ^in_op;
    corrected = in_op;
    dec_sec   = 1'b0;
    dec_ded   = 1'b0;
    if (dec_par) begin
      // Odd overall parity: a single flip, at position s (s=0 is bit 0)
      if (int'(dec_syn) < CODE_W) begin
        corrected = in_op ^ (64'd1 << dec_syn);
        dec_sec   = 1'b1;
      end else begin
        dec_ded = 1'b1;
      end
    end else if (dec_syn != '0) begin
      dec_ded = 1'b1;
    end
  end

  core_out_t stage0;
  core_out_t out_s;

  always_comb begin
    stage0       = '0;
    stage0.valid = in_valid;
    if (in_mode) begin
      stage0.result   = rx_data;
      stage0.sec      = dec_sec;
      stage0.ded      = dec_ded;
      stage0.syndrome = dec_syn;
    end else begin
      stage0.result = codeword;
    end
  end

  // Remaining stages are plain delay registers on the computed payload
  if (PIPE_STAGES > 1) begin : g_dly
    core_out_t dly_q [PIPE_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < PIPE_STAGES - 1; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= stage0;
        for (int k = 1; k < PIPE_STAGES - 1; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign out_s = dly_q[PIPE_STAGES-2];
  end else begin : g_nodly
    assign out_s = stage0;
  end

  assign result    = out_s.result;
  assign sec       = out_s.sec;
  assign ded       = out_s.ded;
  assign syndrome  = out_s.syndrome;
  assign valid_out = out_s.valid;

endmodule
`default_nettype wire

// File: rtl/hamming_secded_apb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_secded_apb                                                         |
// | APB slave wrapping the SECDED datapath: register file, BUSY/DONE control,  |
// | wait states on early result reads and saturating error counters.          |
// | Ports:                                                                     |
// |   PCLK, PRESETn            clock, asynchronous active-low reset            |
// |   PADDR[31:0]              byte address (low ADDR_W bits decoded)          |
// |   PSEL, PENABLE, PWRITE    APB control                                     |
// |   PWDATA[31:0]             write data                                      |
// |   PRDATA[31:0]             read data                                       |
// |   PREADY                   0 = wait state                                  |
// |   PSLVERR                  error response                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hamming_secded_apb
  import hamming_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  // Word-aligned offset; byte lane bits and bits above ADDR_W are ignored
  logic [ADDR_W-1:0] reg_off;
  logic              unused_addr;
  assign reg_off     = {PADDR[ADDR_W-1:2], 2'b00};
  assign unused_addr = ^{PADDR[31:ADDR_W], PADDR[1:0]};

  logic hit_ctrl, hit_din_lo, hit_din_hi, hit_dout_lo, hit_dout_hi, hit_status, hit_err_cnt;
  logic mapped;

  assign hit_ctrl    = (reg_off == OFF_CTRL[ADDR_W-1:0]);
  assign hit_din_lo  = (reg_off == OFF_DIN_LO[ADDR_W-1:0]);
  assign hit_din_hi  = (reg_off == OFF_DIN_HI[ADDR_W-1:0]);
  assign hit_dout_lo = (reg_off == OFF_DOUT_LO[ADDR_W-1:0]);
  assign hit_dout_hi = (reg_off == OFF_DOUT_HI[ADDR_W-1:0]);
  assign hit_status  = (reg_off == OFF_STATUS[ADDR_W-1:0]);
  assign hit_err_cnt = (reg_off == OFF_ERR_CNT[ADDR_W-1:0]);
  assign mapped      = hit_ctrl | hit_din_lo | hit_din_hi | hit_dout_lo |
                       hit_dout_hi | hit_status | hit_err_cnt;

  // Architectural state
  logic             mode;
  logic [31:0]      din_lo;
  logic [31:0]      din_hi;
  logic [63:0]      dout;
  logic             busy;
  logic             done;
  logic             sec_flag;
  logic             ded_flag;
  logic [SYN_W-1:0] syn_q;
  logic [15:0]      cnt_corr;
  logic [15:0]      cnt_unc;

  logic access;
  logic wr_commit;
  logic wr_blocked;
  logic start;
  logic clr_cnt;

  assign access = PSEL & PENABLE;

  // Result reads stall until the in-flight operation retires
  assign PREADY = !(access && (hit_dout_lo || hit_dout_hi) && busy);

  assign wr_commit = access & PWRITE & PREADY;

  // Operand and mode changes are refused while an operation is in flight;
  // a CTRL write that keeps MODE unchanged is still allowed (CLR_CNT).
  assign wr_blocked = PWRITE && busy &&
                      (hit_din_lo || hit_din_hi || (hit_ctrl && (PWDATA[0] != mode)));

  assign PSLVERR = access && PREADY && (!mapped || wr_blocked);

  assign start   = wr_commit && hit_din_lo && !busy;
  assign clr_cnt = wr_commit && hit_ctrl && PWDATA[1];

  logic [63:0]      core_result;
  logic             core_sec;
  logic             core_ded;
  logic [SYN_W-1:0] core_syn;
  logic             core_valid;

  hamming_secded_core #(
    .DATA_W      (DATA_W),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_core (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .mode      (mode),
    .operand   ({din_hi, PWDATA}),
    .valid     (start),
    .result    (core_result),
    .sec       (core_sec),
    .ded       (core_ded),
    .syndrome  (core_syn),
    .valid_out (core_valid)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode     <= 1'b0;
      din_lo   <= '0;
      din_hi   <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sec_flag <= 1'b0;
      ded_flag <= 1'b0;
      syn_q    <= '0;
      cnt_corr <= '0;
      cnt_unc  <= '0;
    end else begin
      if (wr_commit && hit_ctrl && !busy) mode <= PWDATA[0];
      if (wr_commit && hit_din_hi && !busy) din_hi <= PWDATA;

      if (start) begin
        din_lo <= PWDATA;
        busy   <= 1'b1;
        done   <= 1'b0;
      end

      if (core_valid) begin
        dout     <= core_result;
        sec_flag <= core_sec;
        ded_flag <= core_ded;
        syn_q    <= core_syn;
        busy     <= 1'b0;
        done     <= 1'b1;
      end

      // Clear takes priority over a same-cycle increment
      if (clr_cnt) begin
        cnt_corr <= '0;
        cnt_unc  <= '0;
      end else if (core_valid) begin
        if (core_sec && cnt_corr != CNT_MAX) cnt_corr <= cnt_corr + 16'd1;
        if (core_ded && cnt_unc != CNT_MAX) cnt_unc <= cnt_unc + 16'd1;
      end
    end
  end

  logic [31:0] status_word;
  logic [31:0] rd_mux;

  always_comb begin
    status_word                          = '0;
    status_word[ST_BUSY]                 = busy;
    status_word[ST_DONE]                 = done;
    status_word[ST_SEC]                  = sec_flag;
    status_word[ST_DED]                  = ded_flag;
    status_word[ST_SYN_LSB +: SYN_W]     = syn_q;
  end

  always_comb begin
    rd_mux = '0;
    if (hit_ctrl)    rd_mux = {31'd0, mode};
    if (hit_din_lo)  rd_mux = din_lo;
    if (hit_din_hi)  rd_mux = din_hi;
    if (hit_dout_lo) rd_mux = dout[31:0];
    if (hit_dout_hi) rd_mux = dout[63:32];
    if (hit_status)  rd_mux = status_word;
    if (hit_err_cnt) rd_mux = {cnt_unc, cnt_corr};
  end

  assign PRDATA = (access && !PWRITE) ? rd_mux : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_apb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hamming_secded_apb                                                      |
// | Directed bench for hamming_secded_apb. Three instances:                    |
// |   dev 0: DATA_W=32, PIPE_STAGES=2                                          |
// |   dev 1: DATA_W=8,  PIPE_STAGES=1                                          |
// |   dev 2: DATA_W=57, PIPE_STAGES=4                                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hamming_secded_apb;

  localparam int N_DEV = 3;

  localparam logic [31:0] A_CTRL    = 32'h00;
  localparam logic [31:0] A_DIN_LO  = 32'h04;
  localparam logic [31:0] A_DIN_HI  = 32'h08;
  localparam logic [31:0] A_DOUT_LO = 32'h0C;
  localparam logic [31:0] A_DOUT_HI = 32'h10;
  localparam logic [31:0] A_STATUS  = 32'h14;
  localparam logic [31:0] A_ERR_CNT = 32'h18;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           paddr;
  logic [31:0]           pwdata;
  logic                  penable;
  logic                  pwrite;
  logic [N_DEV-1:0]      psel;
  logic [N_DEV-1:0][31:0] prdata;
  logic [N_DEV-1:0]      pready;
  logic [N_DEV-1:0]      pslverr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_secded_apb #(.DATA_W(32), .PIPE_STAGES(2), .ADDR_W(5)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  hamming_secded_apb #(.DATA_W(8), .PIPE_STAGES(1), .ADDR_W(5)) dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  hamming_secded_apb #(.DATA_W(57), .PIPE_STAGES(4), .ADDR_W(5)) dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  // One APB transfer; entered just after a clock edge, returns 1ns after the
  // commit edge so calls chain back to back.
  task automatic xfer(input int dev, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int waits);
    paddr     = addr;
    pwrite    = wr;
    pwdata    = wdata;
    psel      = '0;
    psel[dev] = 1'b1;
    penable   = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    @(negedge clk);
    while (!pready[dev] && waits < 16) begin
      waits++;
      @(negedge clk);
    end
    total++;
    if (!pready[dev]) begin
      bad++;
      $display("FAIL apb_ready dev=%0d addr=%h: PREADY=0 after %0d waits, required 1", dev, addr, waits);
    end
    rdata = prdata[dev];
    err   = pslverr[dev];
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr(input int dev, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    int          w;
    xfer(dev, 1'b1, addr, data, d, e, w);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    int          w;
    rst_n   = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (2) @(negedge clk);
    total++;
    if (pready !== 3'b111 || pslverr !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: PREADY=%b PSLVERR=%b, required 111/000", pready, pslverr);
    end
    total++;
    if (prdata[0] !== 32'd0) begin
      bad++;
      $display("FAIL reset_prdata: got %h, required 0", prdata[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a <= 'h18; a += 4) begin
      xfer(0, 1'b0, 32'(a), 32'd0, d, e, w);
      total++;
      if (d !== 32'd0 || e !== 1'b0 || w != 0) begin
        bad++;
        $display("FAIL reset_reg_%02h: data=%h err=%b waits=%0d, required 0/0/0", a, d, e, w);
      end
    end
    xfer(0, 1'b0, 32'h1C, 32'd0, d, e, w);
    total++;
    if (d !== 32'd0 || e !== 1'b1) begin
      bad++;
      $display("FAIL unmapped_1c: data=%h err=%b, required 0/1", d, e);
    end
  endtask

  task automatic test_encode();
    logic [31:0] d;
    logic        e;
    int          w;
    wr(0, A_CTRL, 32'h0);
    wr(0, A_DIN_HI, 32'h0);
    wr(0, A_DIN_LO, 32'h1);
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0000000F || w != 1) begin
      bad++;
      $display("FAIL enc1_dout_lo: data=%h waits=%0d, required 0000000f/1", d, w);
    end
    xfer(0, 1'b0, A_DOUT_HI, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL enc1_dout_hi: got %h, required 0", d);
    end
    xfer(0, 1'b0, A_STATUS, 32'd0, d, e, w);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL enc1_status: got %h, required 2", d);
    end
    // data=2 sits at position 5 -> parity at 1 and 4, overall parity 1
    wr(0, A_DIN_LO, 32'h2);
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h00000033 || w != 1) begin
      bad++;
      $display("FAIL enc2_dout_lo: data=%h waits=%0d, required 00000033/1", d, w);
    end
    // Single-stage instance: no wait state on the immediate read
    wr(1, A_CTRL, 32'h0);
    wr(1, A_DIN_LO, 32'h1);
    xfer(1, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0000000F || w != 0) begin
      bad++;
      $display("FAIL enc8_dout_lo: data=%h waits=%0d, required 0000000f/0", d, w);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic        e;
    int          w;
    wr(0, A_CTRL, 32'h1);
    wr(0, A_DIN_LO, 32'h2F);
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL dec_sec_data: got %h, required 1", d);
    end
    xfer(0, 1'b0, A_STATUS, 32'd0, d, e, w);
    total++;
    if (d !== 32'h506) begin
      bad++;
      $display("FAIL dec_sec_status: got %h, required 506", d);
    end
    xfer(0, 1'b0, A_ERR_CNT, 32'd0, d, e, w);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL dec_sec_cnt: got %h, required 1", d);
    end
    wr(0, A_DIN_LO, 32'h6F);
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h7) begin
      bad++;
      $display("FAIL dec_ded_data: got %h, required 7", d);
    end
    xfer(0, 1'b0, A_STATUS, 32'd0, d, e, w);
    total++;
    if (d !== 32'h30A) begin
      bad++;
      $display("FAIL dec_ded_status: got %h, required 30a", d);
    end
    xfer(0, 1'b0, A_ERR_CNT, 32'd0, d, e, w);
    total++;
    if (d !== 32'h00010001) begin
      bad++;
      $display("FAIL dec_ded_cnt: got %h, required 00010001", d);
    end
  endtask

  // CLR_CNT write commits on the same edge the SEC result retires
  task automatic test_clear_collision();
    logic [31:0] d;
    logic        e;
    int          w;
    wr(0, A_DIN_LO, 32'h2F);
    wr(0, A_CTRL, 32'h3);
    xfer(0, 1'b0, A_STATUS, 32'd0, d, e, w);
    total++;
    if (d !== 32'h506) begin
      bad++;
      $display("FAIL clr_status: got %h, required 506", d);
    end
    xfer(0, 1'b0, A_ERR_CNT, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL clr_cnt: got %h, required 0", d);
    end
    xfer(0, 1'b0, A_CTRL, 32'd0, d, e, w);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL clr_ctrl_read: got %h, required 1", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e;
    int          w;
    wr(0, A_CTRL, 32'h0);
    wr(0, A_DIN_LO, 32'h1);
    xfer(0, 1'b1, A_DIN_LO, 32'h2, d, e, w);
    total++;
    if (e !== 1'b1) begin
      bad++;
      $display("FAIL busy_din_err: PSLVERR=%b, required 1", e);
    end
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0000000F) begin
      bad++;
      $display("FAIL busy_din_result: got %h, required 0000000f", d);
    end
    xfer(0, 1'b0, A_DIN_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL busy_din_kept: got %h, required 1", d);
    end
    wr(0, A_DIN_LO, 32'h1);
    xfer(0, 1'b1, A_CTRL, 32'h1, d, e, w);
    total++;
    if (e !== 1'b1) begin
      bad++;
      $display("FAIL busy_mode_err: PSLVERR=%b, required 1", e);
    end
    xfer(0, 1'b0, A_CTRL, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL busy_mode_kept: got %h, required 0", d);
    end
    // STATUS reads never stall and show BUSY=1, DONE=0 mid-operation
    wr(0, A_DIN_LO, 32'h2);
    xfer(0, 1'b0, A_STATUS, 32'd0, d, e, w);
    total++;
    if (d !== 32'h1 || w != 0) begin
      bad++;
      $display("FAIL busy_status: data=%h waits=%0d, required 1/0", d, w);
    end
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h33) begin
      bad++;
      $display("FAIL busy_status_result: got %h, required 33", d);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    logic        e;
    int          w;
    wr(0, A_DIN_LO, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    xfer(0, 1'b0, A_STATUS, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL midreset_status: got %h, required 0", d);
    end
    xfer(0, 1'b0, A_DOUT_LO, 32'd0, d, e, w);
    total++;
    if (d !== 32'h0 || w != 0) begin
      bad++;
      $display("FAIL midreset_dout: data=%h waits=%0d, required 0/0", d, w);
    end
  endtask

  task automatic test_roundtrip(input int dev, input int data_w, input int code_w,
                                input int pipe, input int n);
    for (int it = 0; it < n; it++) begin
      logic [63:0] data;
      logic [63:0] cw;
      logic [63:0] rx;
      logic [63:0] got;
      logic [31:0] lo;
      logic [31:0] hi;
      logic [31:0] st;
      logic [31:0] exp_st;
      logic        e;
      int          w;
      int          a;
      int          b;
      int          nflip;
      data  = {32'($urandom), 32'($urandom)} & ((64'd1 << data_w) - 64'd1);
      nflip = it % 3;
      wr(dev, A_CTRL, 32'h0);
      wr(dev, A_DIN_HI, data[63:32]);
      wr(dev, A_DIN_LO, data[31:0]);
      xfer(dev, 1'b0, A_DOUT_LO, 32'd0, lo, e, w);
      total++;
      if (w != pipe - 1) begin
        bad++;
        $display("FAIL rt_waits dev=%0d: waits=%0d, required %0d", dev, w, pipe - 1);
      end
      xfer(dev, 1'b0, A_DOUT_HI, 32'd0, hi, e, w);
      cw = {hi, lo};
      total++;
      if ((^cw) !== 1'b0) begin
        bad++;
        $display("FAIL rt_cw_parity dev=%0d: codeword %h has odd parity, required even", dev, cw);
      end
      a = $urandom_range(code_w - 1, 0);
      b = a;
      while (b == a) b = $urandom_range(code_w - 1, 0);
      rx = cw;
      if (nflip >= 1) rx[a] = ~rx[a];
      if (nflip == 2) rx[b] = ~rx[b];
      wr(dev, A_CTRL, 32'h1);
      wr(dev, A_DIN_HI, rx[63:32]);
      wr(dev, A_DIN_LO, rx[31:0]);
      xfer(dev, 1'b0, A_DOUT_LO, 32'd0, lo, e, w);
      xfer(dev, 1'b0, A_DOUT_HI, 32'd0, hi, e, w);
      xfer(dev, 1'b0, A_STATUS, 32'd0, st, e, w);
      got = {hi, lo};
      if (nflip < 2) begin
        total++;
        if (got !== data) begin
          bad++;
          $display("FAIL rt_data dev=%0d flips=%0d: got %h, required %h", dev, nflip, got, data);
        end
      end
      if (nflip == 0)      exp_st = 32'h2;
      else if (nflip == 1) exp_st = 32'h6 | (32'(a) << 8);
      else                 exp_st = 32'hA | (32'(a ^ b) << 8);
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL rt_status dev=%0d flips=%0d pos=%0d/%0d: got %h, required %h",
                 dev, nflip, a, b, st, exp_st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode();
    test_clear_collision();
    test_back_to_back();
    test_reset_midop();
    test_roundtrip(1, 8, 13, 1, 9);
    test_roundtrip(2, 57, 64, 4, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
